microcode_sequencer: RTL and testbench

//  Parametrised, writable-control-store microcode sequencer for the bus-based RISC-V core.

---
 rtl/microcode_sequencer_if.sv | 35 +++
 rtl/microcode_sequencer.sv | 149 ++++++++++++++
 tb/tb_microcode_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/microcode_sequencer_if.sv
// rtl/microcode_sequencer_if.sv - IR/flag inputs, store/table write ports and control outputs of the microcode sequencer
interface microcode_sequencer_if #(
    parameter int UADDR_W = 8,
    parameter int CTRL_W  = 22,
    parameter int KEY_W   = 11
);
    logic [6:0]                  Opcode;
    logic [2:0]                  funct3;
    logic [6:0]                  funct7;
    logic                        zero;
    logic                        busy;
    logic                        hold;
    logic                        us_we;
    logic [UADDR_W-1:0]          us_addr;
    logic [CTRL_W+4+UADDR_W-1:0] us_wdata;
    logic                        dt_we;
    logic [KEY_W-1:0]            dt_key;
    logic [UADDR_W:0]            dt_wdata;
    logic [CTRL_W-1:0]           ctrl;
    logic [UADDR_W-1:0]          mpc;
    logic                        illegal_op;
    logic                        stack_err;

    modport master (
        output Opcode, funct3, funct7, zero, busy, hold,
        output us_we, us_addr, us_wdata, dt_we, dt_key, dt_wdata,
        input  ctrl, mpc, illegal_op, stack_err
    );

    modport slave (
        input  Opcode, funct3, funct7, zero, busy, hold,
        input  us_we, us_addr, us_wdata, dt_we, dt_key, dt_wdata,
        output ctrl, mpc, illegal_op, stack_err
    );
endinterface

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - writable-control-store microcode sequencer with dispatch table
// Optional call stack (CALL/RET, stack_err) built only when USEQ_CALLSTACK_EN is defined.
module microcode_sequencer #(
    parameter int UADDR_W    = 8,
    parameter int CTRL_W     = 22,
    parameter int KEY_W      = 11,
    parameter int RESET_ADDR = 0,
    parameter int FETCH_ADDR = 1,
    parameter int TRAP_ADDR  = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    microcode_sequencer_if.slave bus
);
    localparam int WORD_W = CTRL_W + 4 + UADDR_W;
    localparam int DEPTH  = 1 << UADDR_W;
    localparam int KEYS   = 1 << KEY_W;

    localparam logic [UADDR_W-1:0] RST_A   = UADDR_W'(RESET_ADDR);
    localparam logic [UADDR_W-1:0] FETCH_A = UADDR_W'(FETCH_ADDR);
    localparam logic [UADDR_W-1:0] TRAP_A  = UADDR_W'(TRAP_ADDR);

    localparam logic [3:0] NX_NEXT     = 4'd0;
    localparam logic [3:0] NX_FETCH    = 4'd1;
    localparam logic [3:0] NX_DISPATCH = 4'd2;
    localparam logic [3:0] NX_SPIN     = 4'd3;
    localparam logic [3:0] NX_FNEZ     = 4'd4;
    localparam logic [3:0] NX_FEQZ     = 4'd5;
    localparam logic [3:0] NX_JUMP     = 4'd6;
`ifdef USEQ_CALLSTACK_EN
    localparam logic [3:0] NX_CALL     = 4'd7;
    localparam logic [3:0] NX_RET      = 4'd8;
`endif

    logic [WORD_W-1:0]  store [DEPTH];
    logic [UADDR_W:0]   dtab  [KEYS];

    logic [UADDR_W-1:0] mpc_q, mpc_d, mpc_inc, target;
    logic [WORD_W-1:0]  word;
    logic [3:0]         code;
    logic [KEY_W-1:0]   key;
    logic [UADDR_W:0]   dent;
    logic               ill_q, ill_d;
    logic               unused_funct7;

    assign word          = store[mpc_q];
    assign code          = word[UADDR_W+3:UADDR_W];
    assign target        = word[UADDR_W-1:0];
    assign mpc_inc       = mpc_q + UADDR_W'(1);
    assign key           = KEY_W'({bus.Opcode, bus.funct3, bus.funct7[5]});
    assign dent          = dtab[key];
    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    // Memories are not reset; both write ports may fire in the same cycle.
    always_ff @(posedge clock) begin
        if (bus.us_we) store[bus.us_addr] <= bus.us_wdata;
        if (bus.dt_we) dtab[bus.dt_key]   <= bus.dt_wdata;
    end

`ifdef USEQ_CALLSTACK_EN
    logic [UADDR_W-1:0] stk [4];
    logic [2:0]         sp_q;
    logic               push, pop, err_set, err_q;
    logic [1:0]         top_idx;

    assign top_idx = sp_q[1:0] - 2'd1;

    always_ff @(posedge clock) begin
        if (reset && !bus.hold && push) stk[sp_q[1:0]] <= mpc_inc;
    end
`endif

    always_comb begin
        mpc_d = mpc_q;
        ill_d = 1'b0;
`ifdef USEQ_CALLSTACK_EN
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
`endif
        case (code)
            NX_NEXT:     mpc_d = mpc_inc;
            NX_FETCH:    mpc_d = FETCH_A;
            NX_DISPATCH: begin
                if (dent[UADDR_W]) begin
                    mpc_d = dent[UADDR_W-1:0];
                end else begin
                    mpc_d = TRAP_A;
                    ill_d = 1'b1;
                end
            end
            NX_SPIN:     mpc_d = bus.busy ? mpc_q : mpc_inc;
            NX_FNEZ:     mpc_d = bus.zero ? FETCH_A : mpc_inc;
            NX_FEQZ:     mpc_d = bus.zero ? mpc_inc : FETCH_A;
            NX_JUMP:     mpc_d = target;
`ifdef USEQ_CALLSTACK_EN
            NX_CALL: begin
                if (sp_q == 3'd4) begin
                    mpc_d   = TRAP_A;
                    err_set = 1'b1;
                end else begin
                    mpc_d = target;
                    push  = 1'b1;
                end
            end
            NX_RET: begin
                if (sp_q == 3'd0) begin
                    mpc_d   = TRAP_A;
                    err_set = 1'b1;
                end else begin
                    mpc_d = stk[top_idx];
                    pop   = 1'b1;
                end
            end
`endif
            default:     mpc_d = TRAP_A;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mpc_q <= RST_A;
            ill_q <= 1'b0;
`ifdef USEQ_CALLSTACK_EN
            sp_q  <= 3'd0;
            err_q <= 1'b0;
`endif
        end else if (bus.hold) begin
            ill_q <= 1'b0;
        end else begin
            mpc_q <= mpc_d;
            ill_q <= ill_d;
`ifdef USEQ_CALLSTACK_EN
            if (push)    sp_q  <= sp_q + 3'd1;
            if (pop)     sp_q  <= sp_q - 3'd1;
            if (err_set) err_q <= 1'b1;
`endif
        end
    end

    assign bus.ctrl       = bus.hold ? '0 : word[WORD_W-1 -: CTRL_W];
    assign bus.mpc        = mpc_q;
    assign bus.illegal_op = ill_q;
`ifdef USEQ_CALLSTACK_EN
    assign bus.stack_err  = err_q;
`else
    assign bus.stack_err  = 1'b0;
`endif
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - directed scoreboard bench for microcode_sequencer
module tb_microcode_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    microcode_sequencer_if bus ();
    microcode_sequencer dut (.clock(clk), .reset(rst_n), .bus(bus));

    localparam logic [3:0] NEXT = 4'd0, FETCH = 4'd1, DISPATCH = 4'd2, SPIN = 4'd3;
    localparam logic [3:0] FEQZ = 4'd5, JUMP = 4'd6, CALL = 4'd7, RET = 4'd8, RSVD = 4'd12;
    localparam logic [21:0] NEWC  = 22'h2A_5A5A;
    localparam logic [21:0] NEWC2 = 22'h15_0F0F;

    typedef struct {
        string       tag;
        logic [7:0]  mpc;
        logic [21:0] ctrl;
        logic        ill;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [21:0] model [256];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        err_exp;

    function automatic logic [21:0] pat(int a);
        logic [7:0] b;
        b = 8'(a);
        return {b, ~b, 6'(a * 5 + 3)};
    endfunction

    task automatic expect_out(string tag, int m, logic i, logic e);
        exp_t x;
        x.tag  = tag;
        x.mpc  = 8'(m);
        x.ctrl = bus.hold ? 22'd0 : model[m];
        x.ill  = i;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $error("FAIL scoreboard_empty observed 0 entries expected 1");
            return;
        end
        x = sb.pop_front();
        n_vec++;
        assert (bus.mpc === x.mpc) else begin
            n_bad++;
            $error("FAIL %s mpc observed %0d expected %0d", x.tag, bus.mpc, x.mpc);
        end
        n_vec++;
        assert (bus.ctrl === x.ctrl) else begin
            n_bad++;
            $error("FAIL %s ctrl observed %h expected %h", x.tag, bus.ctrl, x.ctrl);
        end
        n_vec++;
        assert (bus.illegal_op === x.ill) else begin
            n_bad++;
            $error("FAIL %s illegal_op observed %b expected %b", x.tag, bus.illegal_op, x.ill);
        end
        n_vec++;
        assert (bus.stack_err === x.err) else begin
            n_bad++;
            $error("FAIL %s stack_err observed %b expected %b", x.tag, bus.stack_err, x.err);
        end
    endtask

    task automatic step(string tag, int m, logic i, logic e);
        expect_out(tag, m, i, e);
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic peek(string tag, int m, logic i, logic e);
        expect_out(tag, m, i, e);
        #1;
        check_out();
    endtask

    task automatic wr_us(int a, logic [21:0] c, logic [3:0] nx, int t);
        bus.us_we    = 1'b1;
        bus.us_addr  = 8'(a);
        bus.us_wdata = {c, nx, 8'(t)};
        @(posedge clk);
        @(negedge clk);
        bus.us_we = 1'b0;
        model[a]  = c;
    endtask

    task automatic wr_dt(logic [6:0] op, logic [2:0] f3, logic f7b, logic v, int a);
        bus.dt_we    = 1'b1;
        bus.dt_key   = {op, f3, f7b};
        bus.dt_wdata = {v, 8'(a)};
        @(posedge clk);
        @(negedge clk);
        bus.dt_we = 1'b0;
    endtask

    task automatic set_key(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        bus.Opcode = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
    endtask

    initial begin
`ifdef USEQ_CALLSTACK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        bus.zero = 0; bus.busy = 0; bus.hold = 0;
        bus.us_we = 0; bus.us_addr = '0; bus.us_wdata = '0;
        bus.dt_we = 0; bus.dt_key = '0; bus.dt_wdata = '0;
        set_key(7'd51, 3'd0, 7'h20);
        @(negedge clk);

        for (int a = 0; a < 256; a++) wr_us(a, pat(a), NEXT, 0);
        wr_us(0,   pat(0),   FETCH,    0);
        wr_us(1,   pat(1),   DISPATCH, 0);
        wr_us(8,   pat(8),   JUMP,     16);
        wr_us(16,  pat(16),  SPIN,     0);
        wr_us(17,  pat(17),  JUMP,     24);
        wr_us(24,  pat(24),  FEQZ,     0);
        wr_us(25,  pat(25),  JUMP,     40);
        wr_us(40,  pat(40),  CALL,     100);
        wr_us(100, pat(100), RET,      0);
        wr_us(41,  pat(41),  JUMP,     60);
        for (int a = 60; a < 65; a++) wr_us(a, pat(a), CALL, a + 1);
        wr_us(120, pat(120), RSVD,     0);
        wr_dt(7'd51, 3'd0, 1'b1, 1'b1, 8);
        wr_dt(7'd51, 3'd0, 1'b0, 1'b0, 0);
        wr_dt(7'd19, 3'd0, 1'b0, 1'b1, 100);
        wr_dt(7'd3,  3'd2, 1'b0, 1'b1, 120);

        peek("reset_state", 0, 0, 0);
        rst_n = 1'b1;
        step("t1_fetch", 1, 0, 0);
        step("t2_dispatch", 8, 0, 0);
        step("jump_16", 16, 0, 0);
        bus.busy = 1;
        for (int i = 0; i < 3; i++) step("t3_spin_busy", 16, 0, 0);
        bus.busy = 0;
        step("t3_spin_release", 17, 0, 0);
        step("jump_24", 24, 0, 0);
        step("t4_feqz_zero0", 1, 0, 0);
        set_key(7'd51, 3'd0, 7'h00);
        step("t2_invalid", 255, 1, 0);

        bus.hold = 1; bus.busy = 1; bus.zero = 1;
        step("t6_hold_frozen", 255, 0, 0);
        bus.us_we = 1; bus.us_addr = 8'd255; bus.us_wdata = {NEWC, NEXT, 8'd0};
        step("t6_hold_write", 255, 0, 0);
        bus.us_we = 0;
        model[255] = NEWC;
        bus.hold = 0; bus.busy = 0; bus.zero = 0;
        peek("t6_new_ctrl", 255, 0, 0);

        step("t4_wrap", 0, 0, 0);
        set_key(7'd51, 3'd0, 7'h20);
        step("refetch", 1, 0, 0);
        step("redispatch", 8, 0, 0);
        step("rejump_16", 16, 0, 0);
        step("spin_idle", 17, 0, 0);
        step("rejump_24", 24, 0, 0);
        bus.zero = 1;
        step("t4_feqz_zero1", 25, 0, 0);
        bus.zero = 0;
        step("jump_40", 40, 0, 0);
`ifdef USEQ_CALLSTACK_EN
        step("t5_call", 100, 0, 0);
        step("t5_ret", 41, 0, 0);
        step("jump_60", 60, 0, 0);
        for (int a = 61; a < 65; a++) step("t5_nested_call", a, 0, 0);
        step("t5_overflow", 255, 0, 1);
        step("t5_sticky", 0, 0, 1);
`else
        step("call_disabled", 255, 0, 0);
`endif
        rst_n = 1'b0;
        peek("reset_abort", 0, 0, 0);
        @(negedge clk);
        peek("reset_held", 0, 0, 0);
        rst_n = 1'b1;
        set_key(7'd19, 3'd0, 7'h00);
        step("post_reset_fetch", 1, 0, 0);
        step("dispatch_ret", 100, 0, 0);
        step("t5_ret_empty", 255, 0, err_exp);
        step("wrap2", 0, 0, err_exp);
        set_key(7'd3, 3'd2, 7'h00);
        step("fetch_k4", 1, 0, err_exp);
        step("dispatch_k4", 120, 0, err_exp);
        step("reserved_code", 255, 0, err_exp);
        step("wrap3", 0, 0, err_exp);
        set_key(7'd51, 3'd0, 7'h20);
        step("fetch_k1", 1, 0, err_exp);

        bus.dt_we = 1; bus.dt_key = {7'd51, 3'd0, 1'b1}; bus.dt_wdata = {1'b1, 8'd200};
        bus.us_we = 1; bus.us_addr = 8'd200; bus.us_wdata = {NEWC2, NEXT, 8'd0};
        step("dispatch_old_entry", 8, 0, err_exp);
        bus.dt_we = 0; bus.us_we = 0;
        model[200] = NEWC2;
        step("loop_16", 16, 0, err_exp);
        step("loop_17", 17, 0, err_exp);
        step("loop_24", 24, 0, err_exp);
        step("loop_feqz", 1, 0, err_exp);
        step("dispatch_new_entry", 200, 0, err_exp);
        step("after_new_entry", 201, 0, err_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
